prng_key_arbiter: RTL and testbench

- Shares the single free-running random-modulo PRNG output stream among NREQ L1 cache requesters (I-cache, D-cache).
- Each requester uses a KEY_WIDTH-bit randomisation key, for example on a cache flush or re-key event.
- The block arbitrates requests round-robin, assembles the key from KEY_WIDTH/NNUM consecutive PRNG words, and delivers it to the winner with a one-cycle valid pulse.
- No PRNG word is ever delivered to two requesters.

---
 rtl/prng_key_arbiter.sv | 138 +++++++++++++
 tb/tb_prng_key_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prng_key_arbiter.sv
// prng_key_arbiter: shares one free-running PRNG word stream among NREQ
// cache requesters. Requests are arbitrated round-robin in IDLE, the winner's
// key is assembled from WORDS consecutive PRNG words in GATHER, and the key is
// announced with a one-cycle one-hot valid pulse in DELIVER.
// Handshake: req_i is a level held by the requester until it sees its
// key_valid_o bit; key_o is valid only while that bit is high. A requester
// that keeps req_i high afterwards re-enters arbitration at lowest priority.
module prng_key_arbiter #(
    parameter int NREQ      = 2,
    parameter int NNUM      = 16,
    parameter int KEY_WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NNUM-1:0]      rand_i,
    input  logic [NREQ-1:0]      req_i,
    output logic [NREQ-1:0]      key_valid_o,
    output logic [KEY_WIDTH-1:0] key_o,
    output logic                 busy_o
);

    localparam int WORDS = KEY_WIDTH / NNUM;
    localparam int PW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW    = (WORDS > 1) ? $clog2(WORDS) : 1;

    // A key must be made of whole PRNG words and there must be someone to share with.
    generate
        if (KEY_WIDTH % NNUM != 0) begin : g_bad_key_width
            $error("prng_key_arbiter: KEY_WIDTH (%0d) must be a multiple of NNUM (%0d)",
                   KEY_WIDTH, NNUM);
        end
        if (NREQ < 2) begin : g_bad_nreq
            $error("prng_key_arbiter: NREQ (%0d) must be at least 2", NREQ);
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATHER  = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]          winner_q, winner_d;
    logic [CW-1:0]          word_cnt_q, word_cnt_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;

    // Round-robin pick: first set request bit starting at rr_ptr, wrapping modulo NREQ.
    logic                   pick_found;
    logic [PW-1:0]          pick_idx;
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            int idx;
            idx = int'(rr_ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!pick_found && req_i[idx]) begin
                pick_found = 1'b1;
                pick_idx   = PW'(idx);
            end
        end
    end

    // Next-state logic: arbitrate in IDLE, capture one PRNG word per GATHER cycle,
    // advance the round-robin pointer past the winner in DELIVER.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        winner_d   = winner_q;
        word_cnt_d = word_cnt_q;
        key_d      = key_q;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    winner_d   = pick_idx;
                    word_cnt_d = '0;
                    state_d    = GATHER;
                end
            end
            GATHER: begin
                for (int w = 0; w < WORDS; w++) begin
                    if (word_cnt_q == CW'(w)) begin
                        key_d[w*NNUM +: NNUM] = rand_i;
                    end
                end
                word_cnt_d = word_cnt_q + 1'b1;
                if (word_cnt_q == CW'(WORDS - 1)) begin
                    word_cnt_d = '0;
                    state_d    = DELIVER;
                end
            end
            DELIVER: begin
                if (winner_q == PW'(NREQ - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = winner_q + 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any partial key immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            winner_q   <= '0;
            word_cnt_q <= '0;
            key_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            winner_q   <= winner_d;
            word_cnt_q <= word_cnt_d;
            key_q      <= key_d;
        end
    end

    // Outputs decoded from registered state: valid pulse only in DELIVER, one-hot on winner.
    always_comb begin
        key_valid_o = '0;
        if (state_q == DELIVER) begin
            key_valid_o[winner_q] = 1'b1;
        end
    end

    assign key_o  = key_q;
    assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_prng_key_arbiter.sv
// tb_prng_key_arbiter: directed scenarios followed by a randomized request
// phase, all checked every cycle against a transaction-level reference model.
module tb_prng_key_arbiter;

  localparam int NREQ      = 2;
  localparam int NNUM      = 16;
  localparam int KEY_WIDTH = 64;
  localparam int WORDS     = KEY_WIDTH / NNUM;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NNUM-1:0]      rand_i;
  logic [NREQ-1:0]      req_i;
  logic [NREQ-1:0]      key_valid_o;
  logic [KEY_WIDTH-1:0] key_o;
  logic                 busy_o;

  prng_key_arbiter #(
    .NREQ      (NREQ),
    .NNUM      (NNUM),
    .KEY_WIDTH (KEY_WIDTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rand_i      (rand_i),
    .req_i       (req_i),
    .key_valid_o (key_valid_o),
    .key_o       (key_o),
    .busy_o      (busy_o)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit rand_random = 1'b0;

  // reference model: one pending transaction at most
  logic [NNUM-1:0]      rand_hist[int];
  int                   m_start   = -1;
  int                   m_deliver = -1;
  int                   m_winner  = 0;
  int                   m_rr      = 0;
  logic [KEY_WIDTH-1:0] m_key_last = '0;

  // scoreboard of deliveries observed
  int                   dlog_who[$];
  int                   dlog_cyc[$];
  logic [KEY_WIDTH-1:0] exp_q[$];

  task automatic check(input string tag, input logic [KEY_WIDTH-1:0] obs,
                       input logic [KEY_WIDTH-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_start    = -1;
    m_deliver  = -1;
    m_winner   = 0;
    m_rr       = 0;
    m_key_last = '0;
  endtask

  // advance one clock, update the model for the cycle just ended, check the new cycle
  task automatic tick();
    logic [NREQ-1:0]      r;
    logic [NREQ-1:0]      exp_valid;
    logic [KEY_WIDTH-1:0] exp_key;
    bit                   exp_busy;
    int                   c;
    r = req_i;
    c = cyc;
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else if (m_deliver < c && r != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (r[(m_rr + i) % NREQ]) begin
          m_winner = (m_rr + i) % NREQ;
          break;
        end
      end
      m_start   = c + 1;
      m_deliver = c + WORDS + 1;
    end
    cyc++;
    #1;
    if (rand_random) rand_i = NNUM'($urandom);
    else             rand_i = NNUM'(32'h1000 + cyc);
    rand_hist[cyc] = rand_i;

    exp_busy  = (m_deliver >= 0) && (cyc >= m_start) && (cyc <= m_deliver);
    exp_valid = '0;
    if (cyc == m_deliver) begin
      exp_valid[m_winner] = 1'b1;
      exp_key = '0;
      for (int w = 0; w < WORDS; w++) begin
        exp_key[w*NNUM +: NNUM] = rand_hist[m_start + w];
      end
      check("key_at_delivery", key_o, exp_key);
      m_key_last = exp_key;
      m_rr = (m_winner + 1) % NREQ;
      exp_q.push_back(exp_key);
    end else if (!exp_busy) begin
      check("key_held", key_o, m_key_last);
    end
    check("busy", 64'(busy_o), 64'(exp_busy));
    check("key_valid", 64'(key_valid_o), 64'(exp_valid));

    if (key_valid_o != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        if (key_valid_o[i]) dlog_who.push_back(i);
      end
      dlog_cyc.push_back(cyc);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // true when no 16-bit word of a appears in b
  function automatic bit words_disjoint(input logic [KEY_WIDTH-1:0] a,
                                        input logic [KEY_WIDTH-1:0] b);
    bit ok = 1'b1;
    for (int i = 0; i < WORDS; i++) begin
      for (int j = 0; j < WORDS; j++) begin
        if (a[i*NNUM +: NNUM] == b[j*NNUM +: NNUM]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  initial begin
    int t0;
    int n0;
    int n_fair;
    bit alt_ok;
    logic [KEY_WIDTH-1:0] k0;
    logic [KEY_WIDTH-1:0] k1;

    reset  = 1'b1;
    req_i  = '0;
    rand_i = 16'h1000;
    rand_hist[0] = rand_i;
    model_reset();

    // reset state
    #1;
    check("reset_key", key_o, '0);
    check("reset_valid", 64'(key_valid_o), 64'd0);
    check("reset_busy", 64'(busy_o), 64'd0);

    // single request: reset released at cycle 1, req from cycle 3
    tick();
    reset = 1'b0;
    ticks(2);
    req_i = 2'b01;
    ticks(5);
    check("single_valid_c8", 64'(key_valid_o), 64'(2'b01));
    check("single_key_c8", key_o, 64'h1007_1006_1005_1004);
    req_i = '0;
    ticks(4);
    check("single_key_held_c12", key_o, 64'h1007_1006_1005_1004);

    // withdrawn request: req1 for one cycle, pulse still arrives 5 cycles later
    req_i = 2'b10;
    t0 = cyc;
    tick();
    req_i = '0;
    ticks(4);
    check("withdrawn_pulse", 64'(key_valid_o), 64'(2'b10));
    check("withdrawn_when", 64'(cyc), 64'(t0 + 5));
    tick();
    check("withdrawn_idle_busy", 64'(busy_o), 64'd0);

    // simultaneous requests with rr_ptr back at 0
    req_i = 2'b11;
    t0 = cyc;
    n0 = dlog_who.size();
    ticks(5);
    check("simul_first_pulse", 64'(key_valid_o), 64'(2'b01));
    req_i = 2'b10;
    ticks(6);
    check("simul_second_pulse", 64'(key_valid_o), 64'(2'b10));
    check("simul_second_when", 64'(cyc), 64'(t0 + 11));
    req_i = '0;
    ticks(2);
    k0 = exp_q[exp_q.size() - 2];
    k1 = exp_q[exp_q.size() - 1];
    check("simul_count", 64'(dlog_who.size() - n0), 64'd2);
    check("simul_disjoint", 64'(words_disjoint(k0, k1)), 64'd1);

    // fairness: both held for 60 cycles
    n0 = dlog_who.size();
    req_i = 2'b11;
    ticks(60);
    req_i = '0;
    ticks(8);
    n_fair = dlog_who.size() - n0;
    check("fair_count", 64'(n_fair), 64'd10);
    alt_ok = 1'b1;
    for (int i = n0 + 1; i < dlog_who.size(); i++) begin
      if (dlog_who[i] == dlog_who[i-1]) alt_ok = 1'b0;
      if (dlog_cyc[i] - dlog_cyc[i-1] != 6) alt_ok = 1'b0;
    end
    check("fair_alternate", 64'(alt_ok), 64'd1);
    check("fair_first_is_0", 64'(dlog_who[n0]), 64'd0);

    // reset mid-GATHER: make rr_ptr point at 1 first so the post-reset winner is telling
    req_i = 2'b01;
    ticks(5);
    req_i = '0;
    tick();
    req_i = 2'b11;
    ticks(2);
    check("pre_reset_busy", 64'(busy_o), 64'd1);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_key", key_o, '0);
    check("async_reset_valid", 64'(key_valid_o), 64'd0);
    check("async_reset_busy", 64'(busy_o), 64'd0);
    tick();
    reset = 1'b0;
    t0 = cyc;
    n0 = dlog_who.size();
    ticks(5);
    check("post_reset_pulse", 64'(key_valid_o), 64'(2'b01));
    check("post_reset_first_winner", 64'(dlog_who[n0]), 64'd0);
    check("post_reset_when", 64'(dlog_cyc[n0]), 64'(t0 + WORDS + 1));
    req_i = 2'b10;
    ticks(6);
    req_i = '0;
    ticks(2);

    // randomized phase: random PRNG words and random request levels
    rand_random = 1'b1;
    for (int i = 0; i < 400; i++) begin
      req_i = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if ($urandom_range(0, 3) == 0) req_i = '0;
      tick();
    end
    req_i = '0;
    ticks(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
